// File: rtl/mux21_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux21_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 2:1 output mux. Two
//   requesters compete for one DATA_W-bit path; the arbiter owns the mux
//   select, limits each grant to MAX_HOLD consecutive cycles while the other
//   requester waits, and registers the selected data onto y with a valid flag.
//
// Parameters
//   DATA_W    width of each requester data bus and of y
//   MAX_HOLD  max consecutive grant cycles while the other side waits (>=1)
//
// Ports
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous, active-high reset
//   req       in   2       level requests, one bit per requester
//   din0      in   DATA_W  requester 0 data
//   din1      in   DATA_W  requester 1 data
//   gnt       out  2       one-hot grant (00 = idle), registered
//   sel       out  1       mux select (1 = din1), registered
//   y         out  DATA_W  registered mux output
//   y_valid   out  1       y carries data of a granted, still-requesting side
//   gnt_cnt0  out  8       (MUX_ARB_STATS_EN only) saturating G0 entry count
//   gnt_cnt1  out  8       (MUX_ARB_STATS_EN only) saturating G1 entry count
//
// Configuration
//   MUX_ARB_STATS_EN  when defined, adds the gnt_cnt0/gnt_cnt1 statistics.
// -----------------------------------------------------------------------------
module mux21_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic [1:0]        gnt,
  output logic              sel,
  output logic [DATA_W-1:0] y,
  output logic              y_valid
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1
`endif
);

  // A one-bit counter is still needed when MAX_HOLD=1 (it simply stays 0).
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]  w_hold_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [1:0]        r_gnt;
  logic [1:0]        w_gnt_nxt;
  logic              r_sel;
  logic              w_sel_nxt;
  logic [DATA_W-1:0] r_y;
  logic              r_y_valid;
  logic              w_valid_nxt;
  logic              w_hold_max;
  logic              w_enter_g0;
  logic              w_enter_g1;

  assign w_hold_max = (r_hold_cnt == HOLD_LAST);
  assign w_enter_g0 = (w_state_nxt == ST_G0) && (r_state != ST_G0);
  assign w_enter_g1 = (w_state_nxt == ST_G1) && (r_state != ST_G1);

  // Next-state selection: release hand-off, hold-limit pre-emption, RR tie-break.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req == 2'b01) begin
          w_state_nxt = ST_G0;
        end else if (req == 2'b10) begin
          w_state_nxt = ST_G1;
        end else if (req == 2'b11) begin
          // Tie goes to the requester that was not served most recently.
          w_state_nxt = r_last ? ST_G0 : ST_G1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_G0: begin
        if (!req[0]) begin
          w_state_nxt = req[1] ? ST_G1 : ST_IDLE;
        end else if (w_hold_max && req[1]) begin
          w_state_nxt = ST_G1;
        end else begin
          w_state_nxt = ST_G0;
        end
      end
      ST_G1: begin
        if (!req[1]) begin
          w_state_nxt = req[0] ? ST_G0 : ST_IDLE;
        end else if (w_hold_max && req[0]) begin
          w_state_nxt = ST_G0;
        end else begin
          w_state_nxt = ST_G1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Hold counter, last-served tracking and grant/select decode of next state.
  always_comb begin
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last;
    w_gnt_nxt   = 2'b00;
    w_sel_nxt   = r_sel;
    w_valid_nxt = 1'b0;

    if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) begin
      w_hold_nxt = {CNT_W{1'b0}};
    end else if (w_hold_max) begin
      // Limit reached with nobody waiting: keep the grant, restart the window.
      w_hold_nxt = {CNT_W{1'b0}};
    end else begin
      w_hold_nxt = r_hold_cnt + CNT_W'(1);
    end

    if (w_enter_g0) begin
      w_last_nxt = 1'b0;
    end else if (w_enter_g1) begin
      w_last_nxt = 1'b1;
    end else begin
      w_last_nxt = r_last;
    end

    case (w_state_nxt)
      ST_G0: begin
        w_gnt_nxt = 2'b01;
        w_sel_nxt = 1'b0;
      end
      ST_G1: begin
        w_gnt_nxt = 2'b10;
        w_sel_nxt = 1'b1;
      end
      ST_IDLE: begin
        w_gnt_nxt = 2'b00;
        w_sel_nxt = r_sel;
      end
      default: begin
        w_gnt_nxt = 2'b00;
        w_sel_nxt = r_sel;
      end
    endcase

    if (((r_state == ST_G0) && req[0]) || ((r_state == ST_G1) && req[1])) begin
      w_valid_nxt = 1'b1;
    end else begin
      w_valid_nxt = 1'b0;
    end
  end

  // Arbiter state and registered grant/select outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= {CNT_W{1'b0}};
      r_last     <= 1'b1;
      r_gnt      <= 2'b00;
      r_sel      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_last     <= w_last_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
    end
  end

  // Output datapath: uses the registered select, so y lags gnt by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= {DATA_W{1'b0}};
      r_y_valid <= 1'b0;
    end else begin
      r_y       <= r_sel ? din1 : din0;
      r_y_valid <= w_valid_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign y       = r_y;
  assign y_valid = r_y_valid;

`ifdef MUX_ARB_STATS_EN
  logic [7:0] r_gnt_cnt0;
  logic [7:0] r_gnt_cnt1;

  // Saturating counts of grant entries per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_cnt0 <= 8'd0;
      r_gnt_cnt1 <= 8'd0;
    end else begin
      if (w_enter_g0 && (r_gnt_cnt0 != 8'hFF)) begin
        r_gnt_cnt0 <= r_gnt_cnt0 + 8'd1;
      end
      if (w_enter_g1 && (r_gnt_cnt1 != 8'hFF)) begin
        r_gnt_cnt1 <= r_gnt_cnt1 + 8'd1;
      end
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux21_rr_arbiter
//   Directed, self-checking bench for mux21_rr_arbiter (DATA_W=8, MAX_HOLD=4).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_mux21_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] din0;
  logic [7:0] din1;
  logic [1:0] gnt;
  logic       sel;
  logic [7:0] y;
  logic       y_valid;
`ifdef MUX_ARB_STATS_EN
  logic [7:0] gnt_cnt0;
  logic [7:0] gnt_cnt1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  mux21_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din0    (din0),
    .din1    (din1),
    .gnt     (gnt),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid)
`ifdef MUX_ARB_STATS_EN
    ,
    .gnt_cnt0(gnt_cnt0),
    .gnt_cnt1(gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;

    // Reset held with both requesting
    rst = 1'b1; req = 2'b11; din0 = 8'h11; din1 = 8'h22;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_yv", 32'(y_valid), 32'h0);
    tick();
    tick();
    chk("rst_hold_gnt", 32'(gnt), 32'h0);
    chk("rst_hold_yv", 32'(y_valid), 32'h0);

    // Tie from reset: G0 x4, G1 x4, ... for 24 edges
    rst = 1'b0;
    prev_gnt = 2'b01;
    for (int e = 1; e <= 24; e++) begin
      tick();
      exp_gnt = (((e - 1) / 4) % 2 == 1) ? 2'b10 : 2'b01;
      chk($sformatf("tie_gnt_%0d", e), 32'(gnt), 32'(exp_gnt));
      chk($sformatf("tie_sel_%0d", e), 32'(sel), 32'(exp_gnt[1]));
      chk($sformatf("tie_y_%0d", e), 32'(y), (prev_gnt == 2'b10) ? 32'h22 : 32'h11);
      chk($sformatf("tie_yv_%0d", e), 32'(y_valid), (e == 1) ? 32'h0 : 32'h1);
      prev_gnt = exp_gnt;
    end
`ifdef MUX_ARB_STATS_EN
    chk("stats_cnt0", 32'(gnt_cnt0), 32'd3);
    chk("stats_cnt1", 32'(gnt_cnt1), 32'd3);
`endif

    // Both release -> idle
    req = 2'b00;
    tick();
    chk("rel_both_gnt", 32'(gnt), 32'h0);
    tick();
    chk("rel_both_yv", 32'(y_valid), 32'h0);

    // Single requester 0
    req = 2'b01; din0 = 8'hA5; din1 = 8'h3C;
    tick();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_sel", 32'(sel), 32'h0);
    tick();
    chk("single_y", 32'(y), 32'hA5);
    chk("single_yv", 32'(y_valid), 32'h1);
    req = 2'b00;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h0);
    tick();
    chk("drop_yv", 32'(y_valid), 32'h0);
    chk("drop_y_hold", 32'(y), 32'hA5);

    // Solo hold expiry: requester 0 keeps the path past MAX_HOLD
    req = 2'b01; din0 = 8'h5A;
    tick();
    chk("solo_first_gnt", 32'(gnt), 32'h1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("solo_gnt_%0d", c), 32'(gnt), 32'h1);
      chk($sformatf("solo_yv_%0d", c), 32'(y_valid), 32'h1);
    end
    chk("solo_y", 32'(y), 32'h5A);

    // Release hand-off G1 -> G0 with no idle gap
    req = 2'b10; din0 = 8'h0F; din1 = 8'hF0;
    tick();
    chk("ho_g1_gnt", 32'(gnt), 32'h2);
    tick();
    chk("ho_g1_y", 32'(y), 32'hF0);
    chk("ho_g1_yv", 32'(y_valid), 32'h1);
    req = 2'b01;
    tick();
    chk("ho_g0_gnt", 32'(gnt), 32'h1);
    chk("ho_g0_sel", 32'(sel), 32'h0);
    tick();
    chk("ho_g0_y", 32'(y), 32'h0F);
    chk("ho_g0_yv", 32'(y_valid), 32'h1);

    // Async reset pulse mid-grant in G1
    req = 2'b10;
    tick();
    chk("ar_g1_gnt", 32'(gnt), 32'h2);
    tick();
    chk("ar_g1_y", 32'(y), 32'hF0);
    #1 rst = 1'b1;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_sel", 32'(sel), 32'h0);
    chk("ar_y", 32'(y), 32'h0);
    chk("ar_yv", 32'(y_valid), 32'h0);
    #1 rst = 1'b0;
    req = 2'b11;
    tick();
    chk("ar_tie_gnt", 32'(gnt), 32'h1);
    tick();
    chk("ar_tie_y", 32'(y), 32'h0F);
    chk("ar_tie_yv", 32'(y_valid), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
